// File: rtl/conv_stream_feeder_if.sv
// Host load port and CONV_POOL fetch handshake for conv_stream_feeder.
// The master side is the host / CONV_POOL pair; the slave side is the feeder.
interface conv_stream_feeder_if #(
   parameter int unsigned IFM_WIDTH    = 16,
   parameter int unsigned WEIGHT_WIDTH = 16,
   parameter int unsigned LD_WIDTH     = 16
);
   logic                    ld_valid;
   logic                    ld_sel;
   logic [LD_WIDTH-1:0]     ld_data;
   logic                    start_conv;
   logic                    end_pool;
   logic                    ifm_read;
   logic                    wgt_read;
   logic [IFM_WIDTH-1:0]    ifm;
   logic [WEIGHT_WIDTH-1:0] wgt;
   logic                    ready;
   logic                    busy;
   logic                    err;

   modport master (
      output ld_valid, ld_sel, ld_data, start_conv, end_pool, ifm_read, wgt_read,
      input  ifm, wgt, ready, busy, err
   );

   modport slave (
      input  ld_valid, ld_sel, ld_data, start_conv, end_pool, ifm_read, wgt_read,
      output ifm, wgt, ready, busy, err
   );
endinterface

// File: rtl/conv_stream_feeder.sv
// Layer-local IFM / weight store that answers CONV_POOL fetch strobes one cycle later.
// Filled word-by-word from the host load port; streams words in order during a layer run,
// wrapping each read pointer so weights can be re-streamed per output-channel pass.
module conv_stream_feeder #(
   parameter int unsigned IFM_WIDTH    = 16,
   parameter int unsigned WEIGHT_WIDTH = 16,
   parameter int unsigned LD_WIDTH     = 16,
   parameter int unsigned IFM_SIZE     = 13,
   parameter int unsigned KERNEL_SIZE  = 3,
   parameter int unsigned CI           = 3,
   parameter int unsigned CO           = 16
) (
   input logic                clk1,
   input logic                rst_n,
   conv_stream_feeder_if.slave bus_io
);

   localparam int unsigned IFM_WORDS = CI * IFM_SIZE * IFM_SIZE;
   localparam int unsigned WGT_WORDS = CO * CI * KERNEL_SIZE * KERNEL_SIZE;
   localparam int unsigned IPW       = $clog2(IFM_WORDS + 1);
   localparam int unsigned WPW       = $clog2(WGT_WORDS + 1);

   localparam logic [IPW-1:0] IfmFull = IPW'(IFM_WORDS);
   localparam logic [IPW-1:0] IfmLast = IPW'(IFM_WORDS - 1);
   localparam logic [WPW-1:0] WgtFull = WPW'(WGT_WORDS);
   localparam logic [WPW-1:0] WgtLast = WPW'(WGT_WORDS - 1);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StLoad  = 2'd1;
   localparam logic [1:0] StReady = 2'd2;
   localparam logic [1:0] StRun   = 2'd3;

   logic [1:0]     state_q, state_d;
   logic [IPW-1:0] ifm_wr_ptr_q, ifm_wr_ptr_d, ifm_rd_ptr_q, ifm_rd_ptr_d;
   logic [WPW-1:0] wgt_wr_ptr_q, wgt_wr_ptr_d, wgt_rd_ptr_q, wgt_rd_ptr_d;
   logic           err_q, err_d;
   logic           ready_q, busy_q;
   logic           ifm_vld_q, wgt_vld_q;

   logic           ifm_we, wgt_we, ifm_re, wgt_re;
   logic           rd_ok, rewind;
   logic [IPW-1:0] ifm_wr_addr, ifm_rd_addr;
   logic [WPW-1:0] wgt_wr_addr, wgt_rd_addr;

   logic [IFM_WIDTH-1:0]    ibuf [IFM_WORDS];
   logic [WEIGHT_WIDTH-1:0] wbuf [WGT_WORDS];
   logic [IFM_WIDTH-1:0]    ifm_rdata_q;
   logic [WEIGHT_WIDTH-1:0] wgt_rdata_q;

   // Next-state decode: FSM, load pointers, error flag and read pointer advance.
   always_comb begin
      state_d      = state_q;
      ifm_wr_ptr_d = ifm_wr_ptr_q;
      wgt_wr_ptr_d = wgt_wr_ptr_q;
      err_d        = err_q;
      ifm_we       = 1'b0;
      wgt_we       = 1'b0;
      ifm_wr_addr  = ifm_wr_ptr_q;
      wgt_wr_addr  = wgt_wr_ptr_q;
      rd_ok        = 1'b0;
      rewind       = 1'b0;

      case (state_q)
         StIdle, StLoad: begin
            if (bus_io.ld_valid) begin
               if (state_q == StIdle) state_d = StLoad;
               if (!bus_io.ld_sel) begin
                  if (ifm_wr_ptr_q != IfmFull) begin
                     ifm_we       = 1'b1;
                     ifm_wr_ptr_d = ifm_wr_ptr_q + 1'b1;
                  end else begin
                     err_d = 1'b1;
                  end
               end else begin
                  if (wgt_wr_ptr_q != WgtFull) begin
                     wgt_we       = 1'b1;
                     wgt_wr_ptr_d = wgt_wr_ptr_q + 1'b1;
                  end else begin
                     err_d = 1'b1;
                  end
               end
            end
            // Ready is visible in the cycle right after the last word lands.
            if ((ifm_wr_ptr_d == IfmFull) && (wgt_wr_ptr_d == WgtFull)) state_d = StReady;
            if (bus_io.start_conv || bus_io.ifm_read || bus_io.wgt_read) err_d = 1'b1;
         end
         StReady: begin
            if (bus_io.start_conv) begin
               // Start wins over a same-cycle load; that load word is dropped.
               state_d = StRun;
               rewind  = 1'b1;
               rd_ok   = 1'b1;
               if (bus_io.ld_valid) err_d = 1'b1;
            end else begin
               if (bus_io.ifm_read || bus_io.wgt_read) err_d = 1'b1;
               if (bus_io.ld_valid) begin
                  // Reload: both buffers become unloaded, this word goes to address 0.
                  state_d      = StLoad;
                  ifm_wr_ptr_d = '0;
                  wgt_wr_ptr_d = '0;
                  if (!bus_io.ld_sel) begin
                     ifm_we       = 1'b1;
                     ifm_wr_addr  = '0;
                     ifm_wr_ptr_d = IPW'(1);
                  end else begin
                     wgt_we       = 1'b1;
                     wgt_wr_addr  = '0;
                     wgt_wr_ptr_d = WPW'(1);
                  end
               end
            end
         end
         StRun: begin
            rd_ok = 1'b1;
            if (bus_io.ld_valid || bus_io.start_conv) err_d = 1'b1;
            if (bus_io.end_pool) state_d = StReady;
         end
         default: state_d = StIdle;
      endcase

      ifm_rd_addr  = rewind ? '0 : ifm_rd_ptr_q;
      wgt_rd_addr  = rewind ? '0 : wgt_rd_ptr_q;
      ifm_rd_ptr_d = ifm_rd_addr;
      wgt_rd_ptr_d = wgt_rd_addr;
      ifm_re       = rd_ok && bus_io.ifm_read;
      wgt_re       = rd_ok && bus_io.wgt_read;
      if (ifm_re) ifm_rd_ptr_d = (ifm_rd_addr == IfmLast) ? '0 : ifm_rd_addr + 1'b1;
      if (wgt_re) wgt_rd_ptr_d = (wgt_rd_addr == WgtLast) ? '0 : wgt_rd_addr + 1'b1;
   end

   // Control state with synchronous active-low reset.
   always_ff @(posedge clk1) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         ifm_wr_ptr_q <= '0;
         wgt_wr_ptr_q <= '0;
         ifm_rd_ptr_q <= '0;
         wgt_rd_ptr_q <= '0;
         err_q        <= 1'b0;
         ready_q      <= 1'b0;
         busy_q       <= 1'b0;
         ifm_vld_q    <= 1'b0;
         wgt_vld_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         ifm_wr_ptr_q <= ifm_wr_ptr_d;
         wgt_wr_ptr_q <= wgt_wr_ptr_d;
         ifm_rd_ptr_q <= ifm_rd_ptr_d;
         wgt_rd_ptr_q <= wgt_rd_ptr_d;
         err_q        <= err_d;
         ready_q      <= (state_d == StReady);
         busy_q       <= (state_d == StRun);
         ifm_vld_q    <= ifm_re;
         wgt_vld_q    <= wgt_re;
      end
   end

   // IFM RAM: one write port, one registered read port, no reset on storage.
   always_ff @(posedge clk1) begin
      if (ifm_we) ibuf[ifm_wr_addr] <= bus_io.ld_data[IFM_WIDTH-1:0];
      if (ifm_re) ifm_rdata_q <= ibuf[ifm_rd_addr];
   end

   // Weight RAM: one write port, one registered read port, no reset on storage.
   always_ff @(posedge clk1) begin
      if (wgt_we) wbuf[wgt_wr_addr] <= bus_io.ld_data[WEIGHT_WIDTH-1:0];
      if (wgt_re) wgt_rdata_q <= wbuf[wgt_rd_addr];
   end

   // Response is forced to zero on any cycle that did not follow a served strobe.
   assign bus_io.ifm   = ifm_vld_q ? ifm_rdata_q : '0;
   assign bus_io.wgt   = wgt_vld_q ? wgt_rdata_q : '0;
   assign bus_io.ready = ready_q;
   assign bus_io.busy  = busy_q;
   assign bus_io.err   = err_q;

endmodule
